// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // Bubble inserted by ID whenever no fetched instruction is presented.
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic circular FIFO; flush beats push/pop, head reads as zero when empty.
module fetch_queue #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [Width-1:0] i_push_data,
    output logic [Width-1:0] o_head_data,
    output logic [CntW-1:0]  o_count
);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
            r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (i_rst_n && !i_flush && i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_data = (r_count == '0) ? '0 : r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and a prefetch queue feeding ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     QDEPTH   = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int unsigned    CntW     = $clog2(QDEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_dout,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic [CntW-1:0] fq_count
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            w_deq;
    logic            w_enq;
    fq_entry_t       w_push_entry;
    fq_entry_t       w_head_entry;

    assign w_deq = if_valid & if_ready;
    // A full queue still accepts a new entry when the head leaves this cycle.
    assign w_enq = !redirect_valid && !halt && ((fq_count < CntW'(QDEPTH)) || w_deq);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= align_pc(redirect_pc);
        end else if (w_enq) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    assign w_push_entry = '{pc: r_fetch_pc, inst: imem_dout};

    fetch_queue #(
        .Width ($bits(fq_entry_t)),
        .Depth (QDEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .i_rst_n     (reset),
        .i_push      (w_enq),
        .i_pop       (w_deq),
        .i_flush     (redirect_valid),
        .i_push_data (w_push_entry),
        .o_head_data (w_head_entry),
        .o_count     (fq_count)
    );

    assign imem_addr = r_fetch_pc;
    assign if_valid  = (fq_count != '0) && !redirect_valid;
    assign if_pc     = w_head_entry.pc;
    assign if_inst   = w_head_entry.inst;

endmodule
